// File: rtl/state_stimulus_gen.sv
// state_stimulus_gen
//   Generates a test stimulus on one line that feeds a state monitor input.
//   Each start request produces one event sequence: an optional burst of
//   chatter pulses, then a hold at the event level that lasts a whole number
//   of delay units. The line then returns to its idle level.
//
// Parameters
//   TICK_DIV    clock cycles per delay unit (1 s at the 10 kHz system clock)
//   GLITCH_LEN  cycles per chatter half-period
//
// Ports
//   i_clk       clock
//   i_reset     synchronous, active-high reset
//   i_start     one-cycle request to emit a sequence (accepted only in IDLE)
//   i_abort     terminates the sequence in progress
//   i_polarity  idle level of o_signal; the event level is its inverse
//   i_delay     hold time in delay units (0 is treated as 1)
//   i_glitches  number of chatter pulses before the hold
//   o_signal    generated line (registered)
//   o_busy      high while a sequence is in progress (registered)
//   o_done      one-cycle pulse on normal completion (registered)
module state_stimulus_gen #(
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned GLITCH_LEN = 20
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic       i_polarity,
  input  logic [3:0] i_delay,
  input  logic [3:0] i_glitches,
  output logic       o_signal,
  output logic       o_busy,
  output logic       o_done
);

  localparam int unsigned LW = (GLITCH_LEN < 2) ? 1 : $clog2(GLITCH_LEN);

  typedef enum logic [1:0] {
    IDLE,
    CHATTER_ON,
    CHATTER_OFF,
    HOLD
  } state_t;

  state_t        state_q,  state_d;
  logic          pol_q,    pol_d;
  logic [3:0]    glitch_q, glitch_d;
  logic [LW-1:0] len_q,    len_d;
  logic [17:0]   hold_q,   hold_d;
  logic          signal_q, signal_d;
  logic          busy_q,   busy_d;
  logic          done_q,   done_d;

  logic [3:0]    delay_eff;
  logic [17:0]   hold_load;

  // The hold length is computed once at start and kept in the down-counter,
  // so the delay input need not be stored separately. The counter holds
  // (cycles - 1) and its zero value marks the last hold cycle.
  assign delay_eff = (i_delay == 4'd0) ? 4'd1 : i_delay;
  assign hold_load = 18'(32'(delay_eff) * TICK_DIV - 32'd1);

  always_comb begin
    state_d  = state_q;
    pol_d    = pol_q;
    glitch_d = glitch_q;
    len_d    = len_q;
    hold_d   = hold_q;
    signal_d = signal_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        signal_d = i_polarity;
        busy_d   = 1'b0;
        if (i_start && !i_abort) begin
          pol_d    = i_polarity;
          glitch_d = i_glitches;
          hold_d   = hold_load;
          busy_d   = 1'b1;
          signal_d = ~i_polarity;
          if (i_glitches != 4'd0) begin
            state_d = CHATTER_ON;
            len_d   = LW'(GLITCH_LEN - 1);
          end else begin
            state_d = HOLD;
          end
        end
      end

      CHATTER_ON: begin
        if (len_q == '0) begin
          state_d  = CHATTER_OFF;
          len_d    = LW'(GLITCH_LEN - 1);
          signal_d = pol_q;
        end else begin
          len_d = len_q - LW'(1);
        end
      end

      CHATTER_OFF: begin
        if (len_q == '0) begin
          glitch_d = glitch_q - 4'd1;
          signal_d = ~pol_q;
          if (glitch_q == 4'd1) begin
            state_d = HOLD;
          end else begin
            state_d = CHATTER_ON;
            len_d   = LW'(GLITCH_LEN - 1);
          end
        end else begin
          len_d = len_q - LW'(1);
        end
      end

      HOLD: begin
        if (hold_q == '0) begin
          state_d  = IDLE;
          signal_d = pol_q;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          hold_d = hold_q - 18'd1;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    // Abort overrides every transition above, but only once a sequence runs;
    // in IDLE it merely blocks a simultaneous start (handled above).
    if (i_abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      signal_d = pol_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      glitch_d = '0;
      len_d    = '0;
      hold_d   = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      pol_q    <= 1'b0;
      glitch_q <= '0;
      len_q    <= '0;
      hold_q   <= '0;
      signal_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pol_q    <= pol_d;
      glitch_q <= glitch_d;
      len_q    <= len_d;
      hold_q   <= hold_d;
      signal_q <= signal_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_signal = signal_q;
  assign o_busy   = busy_q;
  assign o_done   = done_q;

endmodule

// File: tb/tb_state_stimulus_gen.sv
module tb_state_stimulus_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       pol;
  logic [3:0] delay;
  logic [3:0] glitches;
  logic       sig;
  logic       busy;
  logic       done;

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  state_stimulus_gen #(
    .TICK_DIV  (4),
    .GLITCH_LEN(2)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst),
    .i_start   (start),
    .i_abort   (abort),
    .i_polarity(pol),
    .i_delay   (delay),
    .i_glitches(glitches),
    .o_signal  (sig),
    .o_busy    (busy),
    .o_done    (done)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle; outputs are then sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [2:0] got;
    rst = 1'b1; start = 1'b1; abort = 1'b1; pol = 1'b1;
    delay = 4'd3; glitches = 4'd0;
    tick();
    tick();
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL reset_state got sig/busy/done=%b want 000", got);
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b100) begin
      errors++;
      $display("FAIL reset_release_follow got sig/busy/done=%b want 100", got);
    end
    pol = 1'b0;
    tick();
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL idle_follow_pol0 got sig/busy/done=%b want 000", got);
    end
  endtask

  // polarity=1, delay=3, no glitches: 12 cycles at 0, then done.
  task automatic test_hold_only();
    logic [2:0] got, exp;
    pol = 1'b1; delay = 4'd3; glitches = 4'd0;
    tick();
    start = 1'b1;
    for (int c = 0; c < 14; c++) begin
      tick();
      start = 1'b0;
      got = {sig, busy, done};
      exp = (c < 12) ? 3'b010 : (c == 12) ? 3'b101 : 3'b100;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL hold_only c=%0d got sig/busy/done=%b want %b", c, got, exp);
      end
    end
  endtask

  // polarity=0, delay=1, two glitches: 1,1,0,0,1,1,0,0,1,1,1,1 then done.
  task automatic test_chatter();
    logic [2:0]  got, exp;
    logic [11:0] pat;
    int unsigned ndone;
    pat = 12'b1111_0011_0011;
    ndone = 0;
    pol = 1'b0; delay = 4'd1; glitches = 4'd2;
    tick();
    start = 1'b1;
    for (int c = 0; c < 15; c++) begin
      tick();
      start = 1'b0;
      if (done) ndone++;
      got = {sig, busy, done};
      if (c < 12) exp = {pat[c], 2'b10};
      else if (c == 12) exp = 3'b001;
      else exp = 3'b000;
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL chatter c=%0d got sig/busy/done=%b want %b", c, got, exp);
      end
    end
    vectors++;
    if (ndone !== 1) begin
      errors++;
      $display("FAIL chatter_done_count got %0d want 1", ndone);
    end
  endtask

  // delay=0 and delay=1 both hold for exactly TICK_DIV=4 cycles.
  task automatic test_delay_zero();
    logic [2:0] got, exp;
    for (int d = 0; d < 2; d++) begin
      pol = 1'b1; delay = 4'(d); glitches = 4'd0;
      tick();
      start = 1'b1;
      for (int c = 0; c < 6; c++) begin
        tick();
        start = 1'b0;
        got = {sig, busy, done};
        exp = (c < 4) ? 3'b010 : (c == 4) ? 3'b101 : 3'b100;
        vectors++;
        if (got !== exp) begin
          errors++;
          $display("FAIL delay%0d c=%0d got sig/busy/done=%b want %b", d, c, got, exp);
        end
      end
    end
  endtask

  // One glitch, delay=2: busy 2*1*2 + 8 = 12 cycles. Inputs changed and start
  // re-pulsed mid-sequence must not matter; a start on the done cycle must
  // launch a new 4-cycle sequence on the next cycle.
  task automatic test_back_to_back();
    logic [2:0] got, exp;
    logic       es;
    pol = 1'b1; delay = 4'd2; glitches = 4'd1;
    tick();
    start = 1'b1;
    for (int c = 0; c < 19; c++) begin
      tick();
      start = 1'b0;
      got = {sig, busy, done};
      if (c < 12) begin
        es  = (c == 2 || c == 3) ? 1'b1 : 1'b0;
        exp = {es, 2'b10};
      end else if (c == 12) begin
        exp = 3'b101;
      end else if (c < 17) begin
        exp = 3'b010;
      end else if (c == 17) begin
        exp = 3'b101;
      end else begin
        exp = 3'b100;
      end
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL back_to_back c=%0d got sig/busy/done=%b want %b", c, got, exp);
      end
      if (c == 3)  begin pol = 1'b0; delay = 4'd15; glitches = 4'd5; end
      if (c == 6)  start = 1'b1;
      if (c == 10) begin pol = 1'b1; delay = 4'd0; glitches = 4'd0; end
      if (c == 12) start = 1'b1;
    end
  endtask

  // Abort in CHATTER_ON returns to the latched idle level, then a start
  // together with abort in IDLE is ignored.
  task automatic test_abort();
    logic [2:0] got;
    pol = 1'b0; delay = 4'd5; glitches = 4'd3;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b110) begin
      errors++;
      $display("FAIL abort_pre got sig/busy/done=%b want 110", got);
    end
    pol = 1'b1; abort = 1'b1;
    tick();
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL abort_chatter got sig/busy/done=%b want 000", got);
    end
    start = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b100) begin
      errors++;
      $display("FAIL abort_start_idle got sig/busy/done=%b want 100", got);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      got = {sig, busy, done};
      vectors++;
      if (got !== 3'b100) begin
        errors++;
        $display("FAIL abort_after c=%0d got sig/busy/done=%b want 100", c, got);
      end
    end
  endtask

  // Reset mid-HOLD: line forced low, no done, then follows polarity again.
  task automatic test_reset_mid();
    logic [2:0] got;
    pol = 1'b1; delay = 4'd2; glitches = 4'd0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b010) begin
      errors++;
      $display("FAIL reset_mid_pre got sig/busy/done=%b want 010", got);
    end
    rst = 1'b1;
    tick();
    got = {sig, busy, done};
    vectors++;
    if (got !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid got sig/busy/done=%b want 000", got);
    end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      got = {sig, busy, done};
      vectors++;
      if (got !== 3'b100) begin
        errors++;
        $display("FAIL reset_mid_after c=%0d got sig/busy/done=%b want 100", c, got);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold_only();
    test_chatter();
    test_delay_zero();
    test_back_to_back();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/state_stimulus_gen.md
STATE_STIMULUS_GEN -- requirements
Module: state_stimulus_gen

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10000, giving clock cycles per delay unit (1 s at the 10 kHz system clock).
REQ-002 The block SHALL have parameter GLITCH_LEN, default 20, giving the cycles per chatter half-period (2 ms).
REQ-003 The block SHALL have port i_clk, input, 1, the clock.
REQ-004 The block SHALL have port i_reset, input, 1, the reset: synchronous, active-high.
REQ-005 The block SHALL have port i_start, input, 1, a one-cycle request to emit one event sequence.
REQ-006 The block SHALL have port i_abort, input, 1, which terminates the current sequence.
REQ-007 The block SHALL have port i_polarity, input, 1, the idle level of o_signal; the event level is its inverse.
REQ-008 The block SHALL have port i_delay, input, 4, the hold time in delay units.
REQ-009 The block SHALL have port i_glitches, input, 4, the number of chatter pulses before the hold.
REQ-010 The block SHALL have port o_signal, output, 1, the generated line, which feeds a state monitor input.
REQ-011 The block SHALL have port o_busy, output, 1, high while a sequence is in progress.
REQ-012 The block SHALL have port o_done, output, 1, a one-cycle pulse on normal completion.

Function
REQ-013 All outputs SHALL be registered; states are IDLE, CHATTER_ON, CHATTER_OFF, HOLD.
REQ-014 In IDLE, o_signal SHALL equal i_polarity delayed by one cycle, with o_busy=0 and o_done=0.
REQ-015 A sequence SHALL start when i_start=1 is sampled in IDLE. On that edge the block latches i_polarity, i_delay and i_glitches, and o_busy=1 from the next cycle.
REQ-016 i_start SHALL be ignored while o_busy=1; no request is queued.
REQ-017 When latched glitches G>0, the block SHALL emit G pulses. Each pulse is GLITCH_LEN cycles at the event level (CHATTER_ON) followed by GLITCH_LEN cycles at the idle level (CHATTER_OFF), and the first event-level cycle is the cycle after the start.
REQ-018 When G=0, HOLD SHALL begin on the cycle after the start.
REQ-019 HOLD SHALL drive the event level for H = max(D,1)*TICK_DIV cycles, where D is the latched delay; D=0 is treated as 1.
REQ-020 The delay counter SHALL be 18 bits wide, enough for 15*10000 = 150000, and SHALL never wrap.
REQ-021 Chatter pulses SHALL be counted with a 4-bit down-counter, and the GLITCH_LEN count with a separate counter.
REQ-022 On the cycle after the last HOLD cycle, o_signal SHALL return to the idle level, o_done=1 for exactly one cycle, o_busy=0, and the state SHALL be IDLE.
REQ-023 A new i_start SHALL be accepted on the same cycle that o_done=1.
REQ-024 i_abort=1 in any non-IDLE state SHALL cause, on the next cycle: o_signal at the latched idle level, o_busy=0, o_done=0, state IDLE, and all counters cleared.
REQ-025 If i_abort and i_start are both 1 in IDLE, abort SHALL win and no sequence starts.
REQ-026 Changes on i_polarity, i_delay or i_glitches while o_busy=1 SHALL have no effect on the sequence in progress.
REQ-027 Total busy length SHALL be 2*G*GLITCH_LEN + H cycles exactly.

Reset
REQ-028 i_reset=1 SHALL set state IDLE, o_signal=0, o_busy=0, o_done=0 and all counters to 0, with priority over i_start and i_abort.
REQ-029 Reset asserted mid-sequence SHALL abandon the sequence, and no o_done SHALL be produced.
REQ-030 After reset release, o_signal SHALL follow i_polarity from the first clock edge.

Verification (TICK_DIV=4, GLITCH_LEN=2)
REQ-031 Bench: polarity=1, delay=3, glitches=0, start pulse -> o_signal=0 for 12 cycles, then 1; o_done one cycle; busy 12 cycles.
REQ-032 Bench: polarity=0, delay=1, glitches=2 -> o_signal pattern 1,1,0,0,1,1,0,0 then 1 for 4 cycles; busy 12 cycles; done once.
REQ-033 Bench: delay=0, glitches=0 -> hold 4 cycles, identical to delay=1.
REQ-034 Bench: i_start again during HOLD, and i_delay changed mid-sequence -> no effect; a second start on the o_done cycle -> new sequence begins on the next cycle.
REQ-035 Bench: i_abort in CHATTER_ON, then start and abort together in IDLE -> next cycle o_signal at idle level, busy=0, no done; the simultaneous start is ignored.
REQ-036 Bench: i_reset mid-HOLD with polarity=1 -> o_signal=0, busy=0, no done; after release o_signal=1 on the next edge.
